// File: rtl/game_countdown_timer.sv
// Round countdown timer for the game timebase: prescaled steps, pause,
// bonus time with saturation, and a one-shot expiry pulse.
module game_countdown_timer #(
    parameter int WIDTH = 5,
    parameter int START = 20,
    parameter int DIV   = 1,
    parameter int WARN  = 5
) (
    input  logic             clk_out,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             bonus,
    input  logic [WIDTH-1:0] bonus_amt,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             expire_pulse,
    output logic             warn
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    P_LAST  = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] START_V = WIDTH'(START);
    localparam logic [WIDTH-1:0] WARN_V  = WIDTH'(WARN);
    localparam logic [WIDTH:0]   MAX_V   = {1'b0, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DONE
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [PW-1:0]    presc;
    logic [PW-1:0]    nxt_presc;
    logic [WIDTH-1:0] nxt_count;
    logic [WIDTH:0]   sum;
    logic             step;

    always_comb begin
        nxt_state = state;
        nxt_presc = presc;
        nxt_count = count;
        step      = 1'b0;
        sum       = '0;
        unique case (state)
            IDLE: begin
                nxt_count = START_V;
                if (start) begin
                    nxt_state = RUN;
                    nxt_presc = '0;
                end
            end
            DONE: begin
                nxt_count = '0;
                if (start) begin
                    nxt_state = RUN;
                    nxt_presc = '0;
                    nxt_count = START_V;
                end
            end
            RUN, PAUSED: begin
                if (start) begin
                    nxt_state = RUN;
                    nxt_presc = '0;
                    nxt_count = START_V;
                end else begin
                    // A paused cycle freezes the prescaler; releasing pause
                    // behaves like a running cycle from the held phase.
                    step = !pause && (presc == P_LAST);
                    if (!pause) begin
                        nxt_presc = step ? '0 : presc + 1'b1;
                    end
                    sum = {1'b0, count}
                        + (bonus ? {1'b0, bonus_amt} : '0)
                        - {{WIDTH{1'b0}}, step};
                    nxt_count = (sum > MAX_V) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                    if (sum == '0) begin
                        nxt_state = DONE;
                    end else begin
                        nxt_state = pause ? PAUSED : RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state        <= IDLE;
            count        <= START_V;
            presc        <= '0;
            running      <= 1'b0;
            expired      <= 1'b0;
            expire_pulse <= 1'b0;
            warn         <= 1'b0;
        end else begin
            state        <= nxt_state;
            count        <= nxt_count;
            presc        <= nxt_presc;
            running      <= (nxt_state == RUN);
            expired      <= (nxt_state == DONE);
            expire_pulse <= (nxt_state == DONE) && (state != DONE);
            warn         <= ((nxt_state == RUN) || (nxt_state == PAUSED))
                            && (nxt_count != '0) && (nxt_count <= WARN_V);
        end
    end

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboard bench for game_countdown_timer: default instance plus a
// DIV=4/START=3 instance; each cycle's expectation is tagged by instance.
module tb_game_countdown_timer;

    logic       clk_out = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       bonus = 1'b0;
    logic [4:0] bonus_amt = '0;

    logic [4:0] count1, count2;
    logic running1, expired1, pulse1, warn1;
    logic running2, expired2, pulse2, warn2;

    int checks = 0;
    int failures = 0;

    int         q_tag[$];
    logic [8:0] q_exp[$];
    string      q_name[$];

    always #5 clk_out = ~clk_out;

    game_countdown_timer #(.WIDTH(5), .START(20), .DIV(1), .WARN(5)) dut1 (
        .clk_out(clk_out), .reset(reset), .start(start), .pause(pause),
        .bonus(bonus), .bonus_amt(bonus_amt), .count(count1),
        .running(running1), .expired(expired1),
        .expire_pulse(pulse1), .warn(warn1)
    );

    game_countdown_timer #(.WIDTH(5), .START(3), .DIV(4), .WARN(1)) dut2 (
        .clk_out(clk_out), .reset(reset), .start(start), .pause(pause),
        .bonus(bonus), .bonus_amt(bonus_amt), .count(count2),
        .running(running2), .expired(expired2),
        .expire_pulse(pulse2), .warn(warn2)
    );

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic cyc(input logic r, input logic st, input logic pa,
                       input logic bo, input logic [4:0] amt, input int tag,
                       input logic [4:0] c, input logic ru, input logic ex,
                       input logic pu, input logic wa, input string nm);
        @(negedge clk_out);
        reset = r;
        start = st;
        pause = pa;
        bonus = bo;
        bonus_amt = amt;
        q_tag.push_back(tag);
        q_exp.push_back({c, ru, ex, pu, wa});
        q_name.push_back(nm);
    endtask

    task automatic idle1(input logic [4:0] c, input string nm);
        cyc(0, 0, 0, 0, 0, 1, c, c != 0, c == 0, c == 0,
            (c >= 1) && (c <= 5), nm);
    endtask

    initial begin : monitor
        int         tag;
        logic [8:0] e;
        logic [8:0] got;
        string      nm;
        forever begin
            @(posedge clk_out);
            #1;
            if (q_exp.size() > 0) begin
                tag = q_tag.pop_front();
                e = q_exp.pop_front();
                nm = q_name.pop_front();
                if (tag == 1)
                    got = {count1, running1, expired1, pulse1, warn1};
                else
                    got = {count2, running2, expired2, pulse2, warn2};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got count=%0d run=%b exp=%b pulse=%b warn=%b, want count=%0d run=%b exp=%b pulse=%b warn=%b",
                             nm, got[8:4], got[3], got[2], got[1], got[0],
                             e[8:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin : stim
        int waited;
        cyc(1, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "reset");
        cyc(1, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "reset_hold");
        cyc(0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "idle_hold");
        cyc(0, 1, 0, 0, 0, 1, 20, 1, 0, 0, 0, "start");
        for (int c = 19; c >= 0; c--) idle1(5'(c), "countdown");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, "done_hold");
        cyc(0, 0, 0, 1, 9, 1, 0, 0, 1, 0, 0, "done_bonus_ignored");
        cyc(0, 1, 0, 0, 0, 1, 20, 1, 0, 0, 0, "restart_from_done");
        for (int c = 19; c >= 10; c--) idle1(5'(c), "run_to_10");
        for (int i = 0; i < 7; i++)
            cyc(0, 0, 1, 0, 0, 1, 10, 0, 0, 0, 0, "paused_hold");
        for (int c = 9; c >= 3; c--) idle1(5'(c), "resume");
        cyc(0, 1, 0, 0, 0, 1, 20, 1, 0, 0, 0, "restart_at_3");
        cyc(0, 0, 0, 1, 15, 1, 31, 1, 0, 0, 0, "bonus_saturate");
        for (int c = 30; c >= 1; c--) idle1(5'(c), "run_to_1");
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, "bonus_absorbs_expiry");
        idle1(0, "late_expiry");
        cyc(0, 1, 0, 0, 0, 1, 20, 1, 0, 0, 0, "start_again");
        cyc(0, 0, 1, 0, 0, 1, 20, 0, 0, 0, 0, "pause_enter");
        cyc(0, 0, 1, 1, 3, 1, 23, 0, 0, 0, 0, "paused_bonus");
        cyc(0, 0, 0, 0, 0, 1, 22, 1, 0, 0, 0, "pause_release");
        for (int c = 21; c >= 8; c--) idle1(5'(c), "run_to_8");
        cyc(0, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, "pause_at_8");
        cyc(0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0, "run_to_7");
        cyc(0, 0, 1, 0, 0, 1, 7, 0, 0, 0, 0, "pause_at_7");
        cyc(1, 1, 1, 1, 9, 1, 20, 0, 0, 0, 0, "reset_while_paused");
        cyc(0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, "idle_after_reset");
        cyc(0, 0, 0, 1, 5, 1, 20, 0, 0, 0, 0, "idle_bonus_ignored");

        cyc(1, 0, 0, 0, 0, 2, 3, 0, 0, 0, 0, "div4_reset");
        cyc(0, 1, 0, 0, 0, 2, 3, 1, 0, 0, 0, "div4_start");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 2, 3, 1, 0, 0, 0, "div4_phase");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, "div4_step1");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 0, 0, 2, 2, 0, 0, 0, 0, "div4_paused");
        cyc(0, 0, 0, 0, 0, 2, 2, 1, 0, 0, 0, "div4_resume_phase");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 0, 0, 2, 1, 1, 0, 0, 1, "div4_step2");
        cyc(0, 0, 0, 0, 0, 2, 0, 0, 1, 1, 0, "div4_expire");
        cyc(0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, "div4_done");

        waited = 0;
        while (q_exp.size() > 0 && waited < 20) begin
            @(posedge clk_out);
            waited++;
        end
        #2;
        if (q_exp.size() > 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_countdown_timer.md
GAME_COUNTDOWN_TIMER -- requirements
Module: game_countdown_timer

Interface
REQ-001 Parameter WIDTH, default 5: count width in bits; legal range 2..16.
REQ-002 Parameter START, default 20: value loaded by reset and start; 1 <= START <= 2^WIDTH-1.
REQ-003 Parameter DIV, default 1: clk_out cycles per count step; DIV >= 1.
REQ-004 Parameter WARN, default 5: warning threshold; 0 <= WARN < START.
REQ-005 clk_out  input  1  game timebase clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset, sampled on rising clk_out.
REQ-007 start  input  1  level; sampled each cycle; starts or restarts a round.
REQ-008 pause  input  1  level; while high, a running round is frozen.
REQ-009 bonus  input  1  single-cycle request to add bonus_amt to count.
REQ-010 bonus_amt  input  WIDTH  unsigned value added on bonus.
REQ-011 count  output  WIDTH  remaining time, registered.
REQ-012 running  output  1  high in RUN state only.
REQ-013 expired  output  1  high in DONE state only.
REQ-014 expire_pulse  output  1  high for exactly one cycle on the RUN->DONE transition.
REQ-015 warn  output  1  high when state is RUN or PAUSED and 0 < count <= WARN.

Function
REQ-016 State machine SHALL have four states: IDLE, RUN, PAUSED, DONE.
REQ-017 IDLE: count holds START; start=1 -> RUN, prescaler cleared to 0.
REQ-018 RUN: the prescaler increments each cycle; when it reaches DIV-1 it wraps to 0 and a step occurs, decrementing count by 1.
REQ-019 With DIV=1, a step occurs every cycle in RUN.
REQ-020 RUN: a step that takes count from 1 to 0 SHALL move to DONE, with expire_pulse high in the cycle count first reads 0.
REQ-021 RUN with pause=1 (and start=0) -> PAUSED; no step occurs in that cycle; prescaler and count hold.
REQ-022 PAUSED: count and prescaler hold; pause=0 -> RUN, resuming from the held prescaler value.
REQ-023 DONE: count holds 0; expired=1; bonus is ignored; start=1 -> RUN with count=START and prescaler=0.
REQ-024 start=1 in RUN or PAUSED SHALL restart: count=START, prescaler=0, state RUN; this takes priority over pause, bonus and step.
REQ-025 bonus=1 in RUN or PAUSED: new count = count + bonus_amt - (step ? 1 : 0), computed at WIDTH+1 bits and saturated to 2^WIDTH-1.
REQ-026 If a bonus raises the result of REQ-025 above 0, the round SHALL NOT expire, even when the step alone would have reached 0.
REQ-027 bonus in IDLE is ignored.
REQ-028 count SHALL never underflow below 0 or wrap past 2^WIDTH-1.
REQ-029 Priority, highest first: reset, start, pause, bonus/step.
REQ-030 All outputs SHALL be registered or decoded from registered state only; there is no combinational path from any input to any output.

Reset
REQ-031 reset=1 SHALL force state IDLE, count=START, prescaler=0, running=0, expired=0, expire_pulse=0, warn=0 at the next rising edge, overriding all other inputs.
REQ-032 reset asserted mid-round (RUN, PAUSED or DONE) SHALL behave identically to REQ-031 and produce no expire_pulse.

Verification (WIDTH=5, START=20, DIV=1, WARN=5 unless stated)
REQ-033 reset, then start for 1 cycle -> count 20,19,...,0 on successive cycles; expire_pulse high once, in the cycle count=0; expired stays 1; warn high only for count 5..1.
REQ-034 start, run to count=10, assert pause for 7 cycles -> count stays 10 and running=0; release -> count decrements to 9 on the next edge.
REQ-035 bonus with bonus_amt=15 at count=20 -> count=31 (saturated, step absorbed); bonus_amt=1 at count=1 -> count stays 1, no expiry.
REQ-036 start asserted at count=3 -> count=20 next cycle, state RUN; start asserted in DONE -> count=20, expired=0.
REQ-037 DIV=4, START=3: start -> count changes every 4th cycle; pausing at prescaler=2 and resuming preserves phase; expiry occurs 12 cycles after start.
REQ-038 reset asserted while PAUSED at count=7 -> next cycle count=20, IDLE, all flags 0; start and bonus asserted in the same cycle as reset are ignored.
